// File: rtl/riscv_test_pkg.sv
// Shared types for the RISC-V test sequencer: FSM states and verdict codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_test_pkg;

  localparam int STATUS_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DUT_RST = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_REPORT  = 3'd5
  } seq_state_e;

  typedef enum logic [STATUS_W-1:0] {
    STATUS_NONE     = 3'd0,
    STATUS_PASS     = 3'd1,
    STATUS_FAIL     = 3'd2,
    STATUS_TIMEOUT  = 3'd3,
    STATUS_OVERFLOW = 3'd4
  } status_e;

endpackage

// File: rtl/run_timer.sv
// Run-phase cycle timer: saturating counter with clear/enable and a limit compare.
// Latency: count updates the cycle after enable; expired is decoded from count and limit.
// Backpressure: none; deasserting enable freezes the count.
module run_timer #(
  parameter int TIMEOUT_W = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic [TIMEOUT_W-1:0] count,
  output logic                 expired
);

  // Count enabled cycles, holding at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Expiry fires during the limit-th enabled cycle; a zero limit disables it.
  always_comb begin
    expired = (limit != '0) && (count == limit - 1'b1);
  end

endmodule

// File: rtl/riscv_test_sequencer.sv
// Test sequencer: resets the simulation top, streams a program image into instruction
// memory, releases the core and latches a pass/fail/timeout/overflow verdict.
// Latency: accepted word drives the write port next cycle; full-rate load, no bubbles.
// Backpressure: prog_ready is high only in LOAD; prog_valid elsewhere is left pending.
module riscv_test_sequencer
  import riscv_test_pkg::*;
#(
  parameter int INST_MEM_ADDR_SIZE = 10,
  parameter int TIMEOUT_W          = 20,
  parameter int DUT_RST_CYCLES     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [TIMEOUT_W-1:0]          timeout_limit,
  input  logic [31:0]                   prog_data,
  input  logic                          prog_valid,
  input  logic                          prog_last,
  output logic                          prog_ready,
  output logic                          dut_reset,
  output logic [31:0]                   inst,
  output logic [INST_MEM_ADDR_SIZE-1:0] inst_mem_offset,
  output logic                          programming_data_valid,
  output logic                          programming_done,
  input  logic                          result_valid,
  input  logic                          result_passed,
  output logic                          busy,
  output logic [STATUS_W-1:0]           status,
  output logic                          status_valid,
  output logic [TIMEOUT_W-1:0]          cycle_count,
  output logic [INST_MEM_ADDR_SIZE:0]   words_loaded
);

  localparam int RST_CNT_W = (DUT_RST_CYCLES > 1) ? $clog2(DUT_RST_CYCLES) : 1;
  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(DUT_RST_CYCLES - 1);
  // Index of the final memory slot; a non-last word accepted here overflows the image.
  localparam logic [INST_MEM_ADDR_SIZE:0] LAST_SLOT = {1'b0, {INST_MEM_ADDR_SIZE{1'b1}}};

  seq_state_e                    state_q, state_d;
  status_e                       status_q;
  logic [RST_CNT_W-1:0]          rst_cnt_q;
  logic [TIMEOUT_W-1:0]          limit_q;
  logic [31:0]                   inst_q;
  logic [INST_MEM_ADDR_SIZE-1:0] offset_q;
  logic                          pdv_q;
  logic                          done_q;
  logic [INST_MEM_ADDR_SIZE:0]   words_q;

  logic start_acc;
  logic word_acc;
  logic rst_done;
  logic last_slot;
  logic timer_expired;

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_REPORT));
  assign word_acc  = prog_valid && (state_q == ST_LOAD);
  assign rst_done  = (rst_cnt_q == RST_LAST);
  assign last_slot = (words_q == LAST_SLOT);

  run_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_run_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_acc),
    .enable  (state_q == ST_RUN),
    .limit   (limit_q),
    .count   (cycle_count),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a result arriving on the timeout cycle takes precedence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_REPORT: if (start) state_d = ST_DUT_RST;
      ST_DUT_RST:         if (rst_done) state_d = ST_LOAD;
      ST_LOAD: begin
        if (word_acc) begin
          if (prog_last)      state_d = ST_RELEASE;
          else if (last_slot) state_d = ST_REPORT;
        end
      end
      ST_RELEASE:         state_d = ST_RUN;
      ST_RUN:             if (result_valid || timer_expired) state_d = ST_REPORT;
      default:            state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    prog_ready   = (state_q == ST_LOAD);
    dut_reset    = (state_q == ST_DUT_RST);
    busy         = (state_q != ST_IDLE) && (state_q != ST_REPORT);
    status_valid = (state_q == ST_REPORT);
  end

  // Datapath: run setup, reset hold counter, write port, release pulse and verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q  <= STATUS_NONE;
      rst_cnt_q <= '0;
      limit_q   <= '0;
      inst_q    <= '0;
      offset_q  <= '0;
      pdv_q     <= 1'b0;
      done_q    <= 1'b0;
      words_q   <= '0;
    end else begin
      pdv_q  <= 1'b0;
      done_q <= 1'b0;
      if (start_acc) begin
        status_q  <= STATUS_NONE;
        rst_cnt_q <= '0;
        limit_q   <= timeout_limit;
        words_q   <= '0;
      end
      if ((state_q == ST_DUT_RST) && !rst_done) begin
        rst_cnt_q <= rst_cnt_q + 1'b1;
      end
      if (word_acc) begin
        inst_q   <= prog_data;
        offset_q <= words_q[INST_MEM_ADDR_SIZE-1:0];
        pdv_q    <= 1'b1;
        words_q  <= words_q + 1'b1;
        if (!prog_last && last_slot) status_q <= STATUS_OVERFLOW;
      end
      // Release follows the final write strobe, so the pulse never overlaps it.
      if (state_q == ST_RELEASE) begin
        done_q <= 1'b1;
      end
      if (state_q == ST_RUN) begin
        if (result_valid)       status_q <= result_passed ? STATUS_PASS : STATUS_FAIL;
        else if (timer_expired) status_q <= STATUS_TIMEOUT;
      end
    end
  end

  assign inst                   = inst_q;
  assign inst_mem_offset        = offset_q;
  assign programming_data_valid = pdv_q;
  assign programming_done       = done_q;
  assign status                 = status_q;
  assign words_loaded           = words_q;

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Self-checking bench for riscv_test_sequencer: random images and result timing
// compared against a run-level model of the verdict, cycle count and write stream.
module tb_riscv_test_sequencer;

  localparam int A     = 10;
  localparam int TW    = 20;
  localparam int RSTC  = 4;
  localparam int DEPTH = 1 << A;

  localparam int S_NONE = 0, S_PASS = 1, S_FAIL = 2, S_TIMEOUT = 3, S_OVERFLOW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [TW-1:0] timeout_limit;
  logic [31:0]   prog_data;
  logic          prog_valid;
  logic          prog_last;
  logic          prog_ready;
  logic          dut_reset;
  logic [31:0]   inst;
  logic [A-1:0]  inst_mem_offset;
  logic          programming_data_valid;
  logic          programming_done;
  logic          result_valid;
  logic          result_passed;
  logic          busy;
  logic [2:0]    status;
  logic          status_valid;
  logic [TW-1:0] cycle_count;
  logic [A:0]    words_loaded;

  int errors = 0;
  int checks = 0;

  riscv_test_sequencer #(
    .INST_MEM_ADDR_SIZE (A),
    .TIMEOUT_W          (TW),
    .DUT_RST_CYCLES     (RSTC)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .timeout_limit          (timeout_limit),
    .prog_data              (prog_data),
    .prog_valid             (prog_valid),
    .prog_last              (prog_last),
    .prog_ready             (prog_ready),
    .dut_reset              (dut_reset),
    .inst                   (inst),
    .inst_mem_offset        (inst_mem_offset),
    .programming_data_valid (programming_data_valid),
    .programming_done       (programming_done),
    .result_valid           (result_valid),
    .result_passed          (result_passed),
    .busy                   (busy),
    .status                 (status),
    .status_valid           (status_valid),
    .cycle_count            (cycle_count),
    .words_loaded           (words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed write stream and release pulses, sampled mid-cycle.
  int          wr_off[$];
  logic [31:0] wr_dat[$];
  logic [31:0] img[$];
  int          cyc = 0, last_pdv_cyc = -1, done_cyc = -1, done_cnt = 0;
  int          obs_rst_cycles, obs_run_cycles;

  always @(negedge clk) begin
    cyc++;
    if (programming_data_valid) begin
      wr_off.push_back(int'(inst_mem_offset));
      wr_dat.push_back(inst);
      last_pdv_cyc = cyc;
    end
    if (programming_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    wr_off.delete(); wr_dat.delete();
    last_pdv_cyc = -1; done_cyc = -1; done_cnt = 0;
  endtask

  // Expected verdict of a run: result seen in RUN cycle k (0 = never), limit 0 = none.
  function automatic void model_run(input int k, input bit passed, input int limit,
                                    output int st, output int cycles);
    if (k > 0 && (limit == 0 || k <= limit)) begin
      st = passed ? S_PASS : S_FAIL; cycles = k;
    end else if (limit > 0) begin
      st = S_TIMEOUT; cycles = limit;
    end else begin
      st = S_NONE; cycles = -1;
    end
  endfunction

  // Number of write-stream entries that differ from image words at offsets 0..n-1.
  function automatic int write_errs(input int n);
    int bad = 0;
    if (wr_off.size() != n) bad++;
    for (int i = 0; i < wr_off.size() && i < n; i++)
      if (wr_off[i] != i || wr_dat[i] !== img[i]) bad++;
    return bad;
  endfunction

  // Drives one complete run. gap: 0 full rate, 1 every other cycle, 2 random.
  task automatic run_prog(input int n, input bit with_last, input int gap, input int k,
                          input bit passed, input int limit, input int max_run);
    int idx, guard, r;
    bit v, acc;
    clear_mon();
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
    @(negedge clk);
    start = 1'b1; timeout_limit = limit[TW-1:0];
    @(negedge clk);
    start = 1'b0; timeout_limit = TW'($urandom);
    obs_rst_cycles = 0; guard = 0;
    while (!prog_ready && guard < 50) begin
      if (dut_reset) obs_rst_cycles++;
      prog_valid = 1'b1; prog_data = $urandom; prog_last = 1'b1;
      start = 1'($urandom_range(0, 1)); result_valid = 1'($urandom_range(0, 1));
      @(negedge clk); guard++;
    end
    if (!prog_ready) begin
      checks++; errors++;
      $display("FAIL load_wait: prog_ready=%0b after %0d cycles, required 1", prog_ready, guard);
    end
    idx = 0; guard = 0;
    while (idx < n && guard < 3 * n + 20) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      prog_valid = v; prog_data = img[idx]; prog_last = with_last && (idx == n - 1);
      start = 1'($urandom_range(0, 1)); result_valid = 1'($urandom_range(0, 1));
      acc = v && prog_ready;
      @(negedge clk); guard++;
      if (acc) idx++;
    end
    prog_valid = 1'b0; prog_last = 1'b0; start = 1'b0; result_valid = 1'b0;
    obs_run_cycles = 0;
    if (with_last) begin
      guard = 0;
      while (!programming_done && guard < 10) begin
        @(negedge clk); guard++;
      end
      if (!programming_done) begin
        checks++; errors++;
        $display("FAIL release_wait: programming_done=0 after %0d cycles, required 1", guard);
      end
      r = 1;
      while (!status_valid && r <= max_run) begin
        result_valid  = (r == k);
        result_passed = (r == k) ? passed : 1'($urandom_range(0, 1));
        @(negedge clk);
        obs_run_cycles = r; r++;
      end
      result_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; timeout_limit = '0; prog_data = '0; prog_valid = 1'b0;
    prog_last = 1'b0; result_valid = 1'b0; result_passed = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({prog_ready, dut_reset, programming_data_valid, programming_done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 0000",
                         {prog_ready, dut_reset, programming_data_valid, programming_done});
    end
    checks++; if (inst !== 32'h0 || inst_mem_offset !== '0) begin
      errors++; $display("FAIL reset_port: inst=%h offset=%0d, required 0/0", inst, inst_mem_offset);
    end
    checks++; if (busy !== 1'b0 || status_valid !== 1'b0) begin
      errors++; $display("FAIL reset_busy: busy=%b status_valid=%b, required 0/0", busy, status_valid);
    end
    checks++; if (status !== 3'(S_NONE)) begin
      errors++; $display("FAIL reset_status: got %0d, required %0d", status, S_NONE);
    end
    checks++; if (cycle_count !== '0 || words_loaded !== '0) begin
      errors++; $display("FAIL reset_counts: cycles=%0d words=%0d, required 0/0", cycle_count, words_loaded);
    end
  endtask

  task automatic test_basic_pass();
    run_prog(3, 1'b1, 0, 10, 1'b1, 0, 100);
    repeat (2) @(negedge clk);
    checks++; if (obs_rst_cycles != RSTC) begin
      errors++; $display("FAIL basic_rst_len: got %0d, required %0d", obs_rst_cycles, RSTC);
    end
    checks++; if (write_errs(3) != 0) begin
      errors++; $display("FAIL basic_writes: %0d bad of %0d writes, required 0 bad of 3", write_errs(3), wr_off.size());
    end
    checks++; if (done_cnt != 1 || done_cyc != last_pdv_cyc + 1) begin
      errors++; $display("FAIL basic_release: pulses=%0d at %0d last write %0d, required 1 at next cycle",
                         done_cnt, done_cyc, last_pdv_cyc);
    end
    checks++; if (status !== 3'(S_PASS) || status_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_status: status=%0d valid=%b busy=%b, required %0d/1/0",
                         status, status_valid, busy, S_PASS);
    end
    checks++; if (cycle_count !== TW'(10) || words_loaded !== 11'd3) begin
      errors++; $display("FAIL basic_counts: cycles=%0d words=%0d, required 10/3", cycle_count, words_loaded);
    end
    // A late result in REPORT must not disturb the verdict.
    result_valid = 1'b1; result_passed = 1'b0;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (status !== 3'(S_PASS) || cycle_count !== TW'(10)) begin
      errors++; $display("FAIL report_hold: status=%0d cycles=%0d, required %0d/10", status, cycle_count, S_PASS);
    end
  endtask

  task automatic test_toggle_fail();
    int k, est, ecyc;
    k = $urandom_range(1, 30);
    model_run(k, 1'b0, 0, est, ecyc);
    run_prog(5, 1'b1, 1, k, 1'b0, 0, 100);
    repeat (2) @(negedge clk);
    checks++; if (write_errs(5) != 0) begin
      errors++; $display("FAIL toggle_writes: %0d bad of %0d writes, required 0 bad of 5", write_errs(5), wr_off.size());
    end
    checks++; if (status !== 3'(est) || cycle_count !== TW'(ecyc) || words_loaded !== 11'd5) begin
      errors++; $display("FAIL toggle_verdict: status=%0d cycles=%0d words=%0d, required %0d/%0d/5",
                         status, cycle_count, words_loaded, est, ecyc);
    end
  endtask

  task automatic test_timeout();
    run_prog(4, 1'b1, 2, 0, 1'b0, 50, 200);
    checks++; if (status !== 3'(S_TIMEOUT) || cycle_count !== TW'(50) || obs_run_cycles != 50) begin
      errors++; $display("FAIL timeout_50: status=%0d cycles=%0d run_len=%0d, required %0d/50/50",
                         status, cycle_count, obs_run_cycles, S_TIMEOUT);
    end
    run_prog(3, 1'b1, 0, 0, 1'b0, 0, 2000);
    checks++; if (busy !== 1'b1 || status_valid !== 1'b0 || status !== 3'(S_NONE)) begin
      errors++; $display("FAIL no_timeout: busy=%b valid=%b status=%0d, required 1/0/%0d",
                         busy, status_valid, status, S_NONE);
    end
    checks++; if (cycle_count !== TW'(obs_run_cycles)) begin
      errors++; $display("FAIL no_timeout_count: got %0d, required %0d", cycle_count, obs_run_cycles);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || cycle_count !== '0) begin
      errors++; $display("FAIL run_reset: busy=%b cycles=%0d, required 0/0", busy, cycle_count);
    end
  endtask

  task automatic test_overflow();
    run_prog(DEPTH, 1'b0, 0, 0, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    checks++; if (write_errs(DEPTH) != 0) begin
      errors++; $display("FAIL ovf_writes: %0d bad of %0d writes, required 0 bad of %0d",
                         write_errs(DEPTH), wr_off.size(), DEPTH);
    end
    checks++; if (status !== 3'(S_OVERFLOW) || status_valid !== 1'b1 || words_loaded !== 11'(DEPTH)) begin
      errors++; $display("FAIL ovf_status: status=%0d valid=%b words=%0d, required %0d/1/%0d",
                         status, status_valid, words_loaded, S_OVERFLOW, DEPTH);
    end
    checks++; if (done_cnt != 0 || programming_done !== 1'b0) begin
      errors++; $display("FAIL ovf_release: pulses=%0d, required 0", done_cnt);
    end
  endtask

  task automatic test_coincide();
    int lim, est, ecyc;
    bit p;
    lim = $urandom_range(5, 30);
    p   = 1'($urandom_range(0, 1));
    model_run(lim, p, lim, est, ecyc);
    run_prog(2, 1'b1, 0, lim, p, lim, 100);
    checks++; if (status !== 3'(est) || cycle_count !== TW'(ecyc)) begin
      errors++; $display("FAIL coincide: status=%0d cycles=%0d, required %0d/%0d", status, cycle_count, est, ecyc);
    end
    model_run(lim + 1, 1'b1, lim, est, ecyc);
    run_prog(2, 1'b1, 0, lim + 1, 1'b1, lim, 100);
    checks++; if (status !== 3'(est) || cycle_count !== TW'(ecyc)) begin
      errors++; $display("FAIL late_result: status=%0d cycles=%0d, required %0d/%0d", status, cycle_count, est, ecyc);
    end
  endtask

  task automatic test_reset_mid_load();
    int guard = 0;
    @(negedge clk);
    start = 1'b1; timeout_limit = '0;
    @(negedge clk);
    start = 1'b0;
    while (!prog_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    for (int i = 0; i < 7; i++) begin
      prog_valid = 1'b1; prog_data = $urandom; prog_last = 1'b0;
      @(negedge clk);
    end
    checks++; if (words_loaded !== 11'd7 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_load: words=%0d busy=%b, required 7/1", words_loaded, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; prog_valid = 1'b0;
    checks++; if ({prog_ready, dut_reset, inst, inst_mem_offset, programming_data_valid, programming_done,
                   busy, status, status_valid, cycle_count, words_loaded} !== '0) begin
      errors++; $display("FAIL mid_reset: ready=%b rst=%b inst=%h off=%0d pdv=%b busy=%b st=%0d words=%0d, required all 0",
                         prog_ready, dut_reset, inst, inst_mem_offset, programming_data_valid, busy, status, words_loaded);
    end
    run_prog(4, 1'b1, 0, 3, 1'b1, 0, 100);
    repeat (2) @(negedge clk);
    checks++; if (obs_rst_cycles != RSTC || write_errs(4) != 0) begin
      errors++; $display("FAIL reload: rst_len=%0d bad_writes=%0d, required %0d/0", obs_rst_cycles, write_errs(4), RSTC);
    end
    checks++; if (status !== 3'(S_PASS) || cycle_count !== TW'(3)) begin
      errors++; $display("FAIL reload_status: status=%0d cycles=%0d, required %0d/3", status, cycle_count, S_PASS);
    end
  endtask

  task automatic test_back_to_back();
    int n, gap, lim, k, est, ecyc;
    bit p;
    for (int run = 0; run < 6; run++) begin
      n   = $urandom_range(1, 20);
      gap = $urandom_range(0, 2);
      lim = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 40);
      k   = $urandom_range(1, 45);
      p   = 1'($urandom_range(0, 1));
      model_run(k, p, lim, est, ecyc);
      run_prog(n, 1'b1, gap, k, p, lim, 100);
      repeat (2) @(negedge clk);
      checks++; if (write_errs(n) != 0 || words_loaded !== 11'(n)) begin
        errors++; $display("FAIL b2b_writes run %0d: bad=%0d words=%0d, required 0/%0d", run, write_errs(n), words_loaded, n);
      end
      checks++; if (status !== 3'(est) || cycle_count !== TW'(ecyc)) begin
        errors++; $display("FAIL b2b_verdict run %0d: status=%0d cycles=%0d, required %0d/%0d (k=%0d lim=%0d)",
                           run, status, cycle_count, est, ecyc, k, lim);
      end
      checks++; if (obs_rst_cycles != RSTC || done_cnt != 1 || done_cyc != last_pdv_cyc + 1) begin
        errors++; $display("FAIL b2b_seq run %0d: rst_len=%0d pulses=%0d done=%0d last_wr=%0d, required %0d/1/next",
                           run, obs_rst_cycles, done_cnt, done_cyc, last_pdv_cyc, RSTC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_toggle_fail();
    test_timeout();
    test_overflow();
    test_coincide();
    test_reset_mid_load();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
